// File: rtl/cobalt_pkg.sv
// rtl/cobalt_pkg.sv - shared types for the Cobalt load/store issue queue
package cobalt_pkg;

  localparam int TAG_W = 6;
  localparam int XLEN  = 32;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_kind_e;

  typedef struct packed {
    logic             valid;
    op_kind_e         kind;
    logic             base_rdy;
    logic [TAG_W-1:0] base_tag;
    logic [XLEN-1:0]  base_val;
    logic             data_rdy;
    logic [TAG_W-1:0] data_tag;
    logic [XLEN-1:0]  data_val;
    logic [15:0]      imm;
    logic [TAG_W-1:0] dst_tag;
  } lsq_entry_t;

  function automatic logic [XLEN-1:0] ea_calc(input logic [XLEN-1:0] base,
                                              input logic [15:0] imm);
    return base + {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/ls_operand_slot.sv
// rtl/ls_operand_slot.sv - next-state of one operand: dispatch write plus CDB capture
module ls_operand_slot #(
  parameter int TAG_W = cobalt_pkg::TAG_W
) (
  input  logic             wr_en,
  input  logic             wr_rdy,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_val,
  input  logic             cur_rdy,
  input  logic [TAG_W-1:0] cur_tag,
  input  logic [31:0]      cur_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             nxt_rdy,
  output logic [TAG_W-1:0] nxt_tag,
  output logic [31:0]      nxt_val
);
  import cobalt_pkg::*;

  logic wr_hit;
  logic cur_hit;

  assign wr_hit  = cdb_valid && (cdb_tag == wr_tag);
  assign cur_hit = cdb_valid && !cur_rdy && (cdb_tag == cur_tag);

  always_comb begin
    nxt_rdy = cur_rdy;
    nxt_tag = cur_tag;
    nxt_val = cur_val;
    if (wr_en) begin
      nxt_tag = wr_tag;
      // a broadcast in the dispatch cycle would otherwise be missed forever
      if (wr_rdy) begin
        nxt_rdy = 1'b1;
        nxt_val = wr_val;
      end else if (wr_hit) begin
        nxt_rdy = 1'b1;
        nxt_val = cdb_data;
      end else begin
        nxt_rdy = 1'b0;
        nxt_val = wr_val;
      end
    end else if (cur_hit) begin
      nxt_rdy = 1'b1;
      nxt_val = cdb_data;
    end
  end

endmodule

// File: rtl/ls_issue_queue.sv
// rtl/ls_issue_queue.sv - in-order load/store issue queue feeding the data cache
module ls_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = cobalt_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_is_store,
  input  logic             disp_base_rdy,
  input  logic [TAG_W-1:0] disp_base_tag,
  input  logic [31:0]      disp_base_val,
  input  logic             disp_data_rdy,
  input  logic [TAG_W-1:0] disp_data_tag,
  input  logic [31:0]      disp_data_val,
  input  logic [15:0]      disp_imm,
  input  logic [TAG_W-1:0] disp_dst_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             dc_valid,
  output logic             dc_wen,
  output logic [31:0]      dc_addr,
  output logic [31:0]      dc_wdata,
  output logic [TAG_W-1:0] dc_tag
);
  import cobalt_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  lsq_entry_t       ent_q [DEPTH];
  lsq_entry_t       ent_d [DEPTH];
  lsq_entry_t       hd;

  logic             dc_valid_q, dc_valid_d;
  logic             dc_wen_q, dc_wen_d;
  logic [31:0]      dc_addr_q, dc_addr_d;
  logic [31:0]      dc_wdata_q, dc_wdata_d;
  logic [TAG_W-1:0] dc_tag_q, dc_tag_d;

  logic             enq, can_issue, iss;
  logic             data_wr_rdy;
  logic [31:0]      data_wr_val;
  logic [DEPTH-1:0] slot_wr;

  logic [DEPTH-1:0] b_rdy_n, d_rdy_n;
  logic [TAG_W-1:0] b_tag_n [DEPTH];
  logic [TAG_W-1:0] d_tag_n [DEPTH];
  logic [31:0]      b_val_n [DEPTH];
  logic [31:0]      d_val_n [DEPTH];

  // loads carry no store data: mark it ready with a zero value
  assign data_wr_rdy = disp_is_store ? disp_data_rdy : 1'b1;
  assign data_wr_val = disp_is_store ? disp_data_val : 32'h0;

  assign hd         = ent_q[head_q];
  assign disp_ready = (count_q != CNT_W'(DEPTH));
  assign enq        = disp_valid && disp_ready && !flush;
  assign can_issue  = (count_q != '0) && hd.valid && hd.base_rdy &&
                      ((hd.kind == OP_LOAD) || hd.data_rdy);
  assign iss        = can_issue && !flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign slot_wr[g] = enq && (tail_q == PTR_W'(g));

    ls_operand_slot #(.TAG_W(TAG_W)) u_base (
      .wr_en     (slot_wr[g]),
      .wr_rdy    (disp_base_rdy),
      .wr_tag    (disp_base_tag),
      .wr_val    (disp_base_val),
      .cur_rdy   (ent_q[g].base_rdy),
      .cur_tag   (ent_q[g].base_tag),
      .cur_val   (ent_q[g].base_val),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .nxt_rdy   (b_rdy_n[g]),
      .nxt_tag   (b_tag_n[g]),
      .nxt_val   (b_val_n[g])
    );

    ls_operand_slot #(.TAG_W(TAG_W)) u_data (
      .wr_en     (slot_wr[g]),
      .wr_rdy    (data_wr_rdy),
      .wr_tag    (disp_data_tag),
      .wr_val    (data_wr_val),
      .cur_rdy   (ent_q[g].data_rdy),
      .cur_tag   (ent_q[g].data_tag),
      .cur_val   (ent_q[g].data_val),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .nxt_rdy   (d_rdy_n[g]),
      .nxt_tag   (d_tag_n[g]),
      .nxt_val   (d_val_n[g])
    );
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    dc_valid_d = 1'b0;
    dc_wen_d   = 1'b0;
    dc_addr_d  = dc_addr_q;
    dc_wdata_d = dc_wdata_q;
    dc_tag_d   = dc_tag_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i]          = ent_q[i];
      ent_d[i].base_rdy = b_rdy_n[i];
      ent_d[i].base_tag = b_tag_n[i];
      ent_d[i].base_val = b_val_n[i];
      ent_d[i].data_rdy = d_rdy_n[i];
      ent_d[i].data_tag = d_tag_n[i];
      ent_d[i].data_val = d_val_n[i];
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
    end else begin
      if (enq) begin
        ent_d[tail_q].valid   = 1'b1;
        ent_d[tail_q].kind    = disp_is_store ? OP_STORE : OP_LOAD;
        ent_d[tail_q].imm     = disp_imm;
        ent_d[tail_q].dst_tag = disp_dst_tag;
        tail_d                = tail_q + 1'b1;
      end
      if (iss) begin
        ent_d[head_q].valid = 1'b0;
        head_d              = head_q + 1'b1;
        dc_valid_d          = 1'b1;
        dc_wen_d            = (hd.kind == OP_STORE);
        dc_addr_d           = ea_calc(hd.base_val, hd.imm);
        dc_wdata_d          = hd.data_val;
        dc_tag_d            = hd.dst_tag;
      end
      case ({enq, iss})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      dc_valid_q <= 1'b0;
      dc_wen_q   <= 1'b0;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
      dc_tag_q   <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      dc_valid_q <= dc_valid_d;
      dc_wen_q   <= dc_wen_d;
      dc_addr_q  <= dc_addr_d;
      dc_wdata_q <= dc_wdata_d;
      dc_tag_q   <= dc_tag_d;
    end
  end

  assign dc_valid = dc_valid_q;
  assign dc_wen   = dc_wen_q;
  assign dc_addr  = dc_addr_q;
  assign dc_wdata = dc_wdata_q;
  assign dc_tag   = dc_tag_q;

endmodule
